// File: rtl/crc12_frame_tx.sv
// rtl/crc12_frame_tx.sv - frames a payload byte stream as SYNC, payload, CRC-12 high, CRC-12 low
//
// Purpose:
//   Wraps each upstream payload frame with a leading SYNC byte and a trailing
//   two-byte CRC-12 (poly 0x80F, init 0xFFF, MSB first, no reflection, no
//   final XOR). The CRC covers the payload only and is computed on the fly,
//   so no payload is buffered.
//
// Optional feature (macro CRC12_FRAME_TX_MAXLEN_EN):
//   When defined, a frame reaching MAX_LEN payload bytes without s_last is
//   closed early and err pulses for one cycle. The remaining upstream bytes
//   start a new frame. When undefined, there is no length counter and err is
//   tied to 0.
//
// Ports:
//   clk, arstn         clock, asynchronous active-low reset
//   s_data/s_valid/
//   s_last/s_ready     payload byte stream in
//   m_data/m_valid/
//   m_last/m_ready     framed byte stream out (registered); m_last marks the CRC low byte
//   busy               frame in progress or output byte still pending
//   frame_cnt          completed frames, wraps at 0xFFFF
//   err                over-length truncation pulse
module crc12_frame_tx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 255
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        err
);

  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_max_len_check
    $error("crc12_frame_tx: MAX_LEN must be within 1..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC_HI  = 2'd2,
    CRC_LO  = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [11:0] crc, crc_n;
  logic [7:0]  m_data_n;
  logic        m_valid_n;
  logic        m_last_n;
  logic [15:0] frame_cnt_n;
  logic        slot_free;

`ifdef CRC12_FRAME_TX_MAXLEN_EN
  logic [7:0]  len, len_n;
  logic        err_q, err_n;
`endif

  // One byte of the bit-serial CRC-12 update, MSB of the byte first.
  function automatic logic [11:0] crc12_next(input logic [11:0] c_in, input logic [7:0] d);
    logic [11:0] c;
    logic        fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[11] ^ d[i];
      c  = {c[10:0], 1'b0};
      if (fb) c = c ^ 12'h80F;
    end
    return c;
  endfunction

  // The output register can take a new byte when it is empty or being drained.
  assign slot_free = !m_valid || m_ready;
  assign busy      = (state != IDLE) || m_valid;

  always_comb begin
    state_n     = state;
    crc_n       = crc;
    m_data_n    = m_data;
    m_valid_n   = slot_free ? 1'b0 : m_valid;
    m_last_n    = m_last;
    frame_cnt_n = frame_cnt;
    s_ready     = 1'b0;
`ifdef CRC12_FRAME_TX_MAXLEN_EN
    len_n       = len;
    err_n       = 1'b0;
`endif
    case (state)
      IDLE: begin
        // The waiting payload byte only triggers the SYNC byte; it is taken
        // in PAYLOAD on a later cycle.
        if (s_valid && slot_free) begin
          m_data_n  = SYNC_BYTE;
          m_valid_n = 1'b1;
          m_last_n  = 1'b0;
          crc_n     = 12'hFFF;
`ifdef CRC12_FRAME_TX_MAXLEN_EN
          len_n     = 8'd0;
`endif
          state_n   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        s_ready = slot_free;
        if (s_valid && slot_free) begin
          m_data_n  = s_data;
          m_valid_n = 1'b1;
          m_last_n  = 1'b0;
          crc_n     = crc12_next(crc, s_data);
`ifdef CRC12_FRAME_TX_MAXLEN_EN
          len_n     = len + 8'd1;
          if (s_last) begin
            state_n = CRC_HI;
          end else if (len == 8'(MAX_LEN - 1)) begin
            state_n = CRC_HI;
            err_n   = 1'b1;
          end
`else
          if (s_last) state_n = CRC_HI;
`endif
        end
      end
      CRC_HI: begin
        if (slot_free) begin
          m_data_n  = {4'h0, crc[11:8]};
          m_valid_n = 1'b1;
          m_last_n  = 1'b0;
          state_n   = CRC_LO;
        end
      end
      CRC_LO: begin
        if (slot_free) begin
          m_data_n    = crc[7:0];
          m_valid_n   = 1'b1;
          m_last_n    = 1'b1;
          frame_cnt_n = frame_cnt + 16'd1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      crc       <= 12'hFFF;
      m_data    <= 8'h00;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      frame_cnt <= 16'h0000;
`ifdef CRC12_FRAME_TX_MAXLEN_EN
      len       <= 8'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      crc       <= crc_n;
      m_data    <= m_data_n;
      m_valid   <= m_valid_n;
      m_last    <= m_last_n;
      frame_cnt <= frame_cnt_n;
`ifdef CRC12_FRAME_TX_MAXLEN_EN
      len       <= len_n;
      err_q     <= err_n;
`endif
    end
  end

`ifdef CRC12_FRAME_TX_MAXLEN_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_crc12_frame_tx.sv
// tb/tb_crc12_frame_tx.sv - directed and randomized checks of crc12_frame_tx
module tb_crc12_frame_tx;

`ifdef CRC12_FRAME_TX_MAXLEN_EN
  localparam int ML = 2;
`else
  localparam int ML = 255;
`endif

  logic        clk = 1'b0;
  logic        arstn;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err;

  always #5 clk = ~clk;

  crc12_frame_tx #(.SYNC_BYTE(8'hA5), .MAX_LEN(ML)) dut (
    .clk(clk), .arstn(arstn),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .frame_cnt(frame_cnt), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference CRC-12: shift in one payload bit at a time.
  function automatic logic [11:0] gold_crc(input logic [7:0] bytes[$]);
    int r;
    int fb;
    r = 'hFFF;
    foreach (bytes[k]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = ((r >> 11) & 1) ^ int'(bytes[k][b]);
        r  = (r << 1) & 'hFFF;
        if (fb != 0) r = r ^ 'h80F;
      end
    end
    return 12'(r);
  endfunction

  int          cyc = 0;
  int          start_cyc = 0;
  int          rmode = 0;
  int          pat = 0;
  logic        stall_chk = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_d;
  logic        prev_l;
  int          err_cnt = 0;

  logic [7:0]  payload[$];
  logic [7:0]  cap_d[$];
  logic        cap_l[$];
  int          cap_c[$];
  logic [7:0]  exp_d[$];
  logic        exp_l[$];

  always @(posedge clk) cyc++;

  // Downstream ready: 0 = always, 1 = 1,0,0 pattern, 2 = random, 3 = held low.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: m_ready = 1'b1;
      1: begin m_ready = (pat == 0); pat = (pat + 1) % 3; end
      2: m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (arstn) begin
      if (m_valid && m_ready) begin
        cap_d.push_back(m_data);
        cap_l.push_back(m_last);
        cap_c.push_back(cyc);
      end
      if (err) err_cnt++;
      if (stall_chk) begin
        if (prev_stall) begin
          check("stall_valid", {31'b0, m_valid}, 32'd1);
          check("stall_data", {24'b0, m_data}, {24'b0, prev_d});
          check("stall_last", {31'b0, m_last}, {31'b0, prev_l});
        end
        if (m_valid && !m_ready) check("stall_s_ready", {31'b0, s_ready}, 32'd0);
        prev_stall = m_valid && !m_ready;
        prev_d     = m_data;
        prev_l     = m_last;
      end
    end
  end

  task automatic clear_cap();
    cap_d.delete(); cap_l.delete(); cap_c.delete();
    exp_d.delete(); exp_l.delete();
    err_cnt = 0;
  endtask

  task automatic do_reset();
    arstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    rmode = 0; m_ready = 1'b1; stall_chk = 1'b0; prev_stall = 1'b0; pat = 0;
    repeat (2) @(posedge clk);
    clear_cap();
    #3 arstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive_frame(input int vprob);
    int  n;
    int  g;
    logic acc;
    n = payload.size();
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      g   = 0;
      while (!acc && g < 2000) begin
        s_valid = ($urandom_range(0, 99) < vprob);
        s_data  = payload[i];
        s_last  = (i == n - 1);
        if (i == 0 && g == 0) start_cyc = cyc;
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk); #1;
        g++;
      end
      if (!acc) check("drive_timeout", 32'd0, 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] bytes[$], input logic [11:0] crc);
    exp_d.push_back(8'hA5); exp_l.push_back(1'b0);
    foreach (bytes[k]) begin exp_d.push_back(bytes[k]); exp_l.push_back(1'b0); end
    exp_d.push_back({4'h0, crc[11:8]}); exp_l.push_back(1'b0);
    exp_d.push_back(crc[7:0]);          exp_l.push_back(1'b1);
  endtask

  task automatic wait_done(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (!(int'(frame_cnt) >= n && !m_valid) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, {31'b0, (k < budget)}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_capture(input string tag);
    int n;
    check({tag, "_count"}, cap_d.size(), exp_d.size());
    n = (cap_d.size() < exp_d.size()) ? cap_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), {24'b0, cap_d[i]}, {24'b0, exp_d[i]});
      check($sformatf("%s_last%0d", tag, i), {31'b0, cap_l[i]}, {31'b0, exp_l[i]});
    end
  endtask

  initial begin
    logic [7:0] one[$];
    logic [7:0] b00[$];
    logic [7:0] bff[$];
    int len;
    int nfr;

    arstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b1;
    b00 = {8'h00};
    bff = {8'hFF};
    repeat (3) @(negedge clk);
    check("rst_m_valid",   {31'b0, m_valid}, 32'd0);
    check("rst_m_data",    {24'b0, m_data},  32'h00);
    check("rst_m_last",    {31'b0, m_last},  32'd0);
    check("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
    check("rst_busy",      {31'b0, busy},    32'd0);
    check("rst_s_ready",   {31'b0, s_ready}, 32'd0);
    check("rst_err",       {31'b0, err},     32'd0);

    // Single 0x00 payload: CRC 0x906.
    do_reset();
    payload = b00;
    exp_d = {8'hA5, 8'h00, 8'h09, 8'h06};
    exp_l = {1'b0, 1'b0, 1'b0, 1'b1};
    drive_frame(100);
    wait_done("f00", 1, 200);
    compare_capture("f00");
    if (cap_c.size() == 4) begin
      check("f00_latency", cap_c[0] - start_cyc, 32'd1);
      check("f00_spread",  cap_c[3] - cap_c[0], 32'd3);
    end else check("f00_stamps", cap_c.size(), 32'd4);
    check("f00_frame_cnt", {16'b0, frame_cnt}, 32'd1);

    // Two 0xFF frames back to back: CRC 0xF00, no gap between frames.
    do_reset();
    payload = bff;
    exp_d = {8'hA5, 8'hFF, 8'h0F, 8'h00, 8'hA5, 8'hFF, 8'h0F, 8'h00};
    exp_l = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    drive_frame(100);
    drive_frame(100);
    wait_done("ff2", 2, 200);
    compare_capture("ff2");
    if (cap_c.size() == 8) check("ff2_spread", cap_c[7] - cap_c[0], 32'd7);
    else check("ff2_stamps", cap_c.size(), 32'd8);
    check("ff2_frame_cnt", {16'b0, frame_cnt}, 32'd2);

    // Stalling downstream: bytes held, upstream blocked.
    do_reset();
    rmode = 1; stall_chk = 1'b1;
    payload = b00;
    exp_d = {8'hA5, 8'h00, 8'h09, 8'h06};
    exp_l = {1'b0, 1'b0, 1'b0, 1'b1};
    drive_frame(100);
    wait_done("stall", 1, 400);
    compare_capture("stall");
    stall_chk = 1'b0;
    check("stall_frame_cnt", {16'b0, frame_cnt}, 32'd1);

    // Random frames against the reference CRC.
    do_reset();
    rmode = 2;
    nfr = 20;
    for (int f = 0; f < nfr; f++) begin
`ifdef CRC12_FRAME_TX_MAXLEN_EN
      len = $urandom_range(1, 2);
`else
      len = $urandom_range(1, 64);
`endif
      one.delete();
      for (int k = 0; k < len; k++) one.push_back(8'($urandom_range(0, 255)));
      expect_frame(one, gold_crc(one));
      payload = one;
      drive_frame(70);
    end
    wait_done("rnd", nfr, 20000);
    compare_capture("rnd");
    check("rnd_frame_cnt", {16'b0, frame_cnt}, nfr);
    check("rnd_err", err_cnt, 32'd0);

    // Reset while waiting to emit the CRC high byte.
    do_reset();
    payload = b00;
    drive_frame(100);
    rmode = 3; m_ready = 1'b0;
    @(negedge clk);
    check("crchi_hold_valid", {31'b0, m_valid}, 32'd1);
    check("crchi_hold_data",  {24'b0, m_data},  32'h00);
    #2 arstn = 1'b0;
    #1;
    check("midrst_m_valid", {31'b0, m_valid}, 32'd0);
    check("midrst_busy",    {31'b0, busy},    32'd0);
    check("midrst_m_data",  {24'b0, m_data},  32'h00);
    @(posedge clk);
    clear_cap();
    rmode = 0; m_ready = 1'b1;
    #3 arstn = 1'b1;
    @(posedge clk); #1;
    payload = bff;
    exp_d = {8'hA5, 8'hFF, 8'h0F, 8'h00};
    exp_l = {1'b0, 1'b0, 1'b0, 1'b1};
    drive_frame(100);
    wait_done("postrst", 1, 200);
    compare_capture("postrst");

`ifdef CRC12_FRAME_TX_MAXLEN_EN
    // MAX_LEN=2: three zero bytes split into a truncated frame and a 1-byte frame.
    do_reset();
    payload = {8'h00, 8'h00, 8'h00};
    exp_d = {8'hA5, 8'h00, 8'h00, 8'h03, 8'hA0, 8'hA5, 8'h00, 8'h09, 8'h06};
    exp_l = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    drive_frame(100);
    wait_done("maxlen", 2, 300);
    compare_capture("maxlen");
    check("maxlen_err", err_cnt, 32'd1);
    check("maxlen_frame_cnt", {16'b0, frame_cnt}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/crc12_frame_tx.md
Name: crc12_frame_tx

Overview:
- Framing stage that feeds the CRC-12 engine domain from upstream.
- Accepts a payload byte stream, emits framed bytes: SYNC byte, payload bytes, CRC high byte, CRC low byte.
- Computes CRC-12 over the payload only, on the fly, with no payload buffering:
  - polynomial x^12+x^11+x^3+x^2+x+1 (0x80F)
  - init 0xFFF
  - MSB-first per byte, no reflection, no final XOR
- Sits between the payload source and the serializer/line interface of the transceiver TX path.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame.
- MAX_LEN, 255, maximum payload bytes per frame (1..255). Used only with the optional feature.

Ports:
- clk  input  1  clock
- arstn  input  1  asynchronous reset, active-low
- s_data  input  8  payload byte
- s_valid  input  1  payload byte valid
- s_last  input  1  marks final payload byte of frame
- s_ready  output  1  payload byte accepted when s_valid&&s_ready
- m_data  output  8  framed byte out (registered)
- m_valid  output  1  m_data valid
- m_last  output  1  marks CRC low byte (end of frame)
- m_ready  input  1  downstream accept
- busy  output  1  high in any state other than IDLE
- frame_cnt  output  16  completed frames, wraps 0xFFFF->0
- err  output  1  one-cycle pulse, over-length frame truncated (optional feature only; tied 0 otherwise)

Behaviour:
- Reset: arstn is asynchronous, active-low; clock is clk.
  - State=IDLE, crc=0xFFF, m_data=0, m_valid=0, m_last=0, frame_cnt=0, err=0, length counter=0.
  - Reset mid-frame drops the frame; no partial CRC is ever emitted afterwards.
- slot_free = !m_valid || m_ready.
  - An output register is loaded only when slot_free.
  - If slot_free and nothing is loaded, m_valid<=0.
  - While m_valid && !m_ready, m_data and m_last are held stable.
- FSM states: IDLE, PAYLOAD, CRC_HI, CRC_LO.
  - IDLE: s_ready=0. On s_valid && slot_free: m_data<=SYNC_BYTE, m_valid<=1, m_last<=0, crc<=0xFFF, len<=0, go to PAYLOAD. The payload byte is not consumed in this cycle.
  - PAYLOAD: s_ready=slot_free. On handshake: m_data<=s_data, m_valid<=1, crc<=crc12_next(crc,s_data), len<=len+1. If s_last, go to CRC_HI.
  - CRC_HI: s_ready=0. On slot_free: m_data<={4'h0,crc[11:8]}, m_valid<=1, go to CRC_LO.
  - CRC_LO: s_ready=0. On slot_free: m_data<=crc[7:0], m_valid<=1, m_last<=1, frame_cnt<=frame_cnt+1, go to IDLE.
- CRC bit step, per bit from bit7 down to bit0:
  - fb=crc[11]^d
  - crc=(crc<<1)[11:0]
  - if fb, crc^=0x80F
- Latency: the first framed byte appears one cycle after s_valid is seen in IDLE.
- Throughput: with m_ready held at 1, a frame of N payload bytes occupies N+3 output cycles back-to-back. The next frame's SYNC byte may load in the cycle after CRC_LO is accepted.
- Minimum payload is 1 byte; zero-length frames cannot be formed.
- m_last is cleared when the next byte loads.
- busy=(state!=IDLE) || m_valid.

Optional Feature:
- Macro: CRC12_FRAME_TX_MAXLEN_EN.
- Defined:
  - A payload handshake with len==MAX_LEN-1 and !s_last is treated as last: go to CRC_HI and pulse err for one cycle.
  - Remaining upstream bytes start a new frame.
- Undefined:
  - No length check; len counter is not synthesized; err is tied to 0.

Test Plan:
- Payload {0x00}, s_last on byte 1, m_ready=1 -> m_data A5,00,09,06 on 4 consecutive valid cycles; m_last only on 06; frame_cnt=1.
- Payload {0xFF} -> A5,FF,0F,00; then a second identical frame back-to-back -> 8 consecutive valid bytes; frame_cnt=2.
- Payload {0x00} with m_ready toggling 1,0,0,1,... -> m_data stable while stalled; byte sequence unchanged; s_ready=0 while output is stalled.
- Random 1..64-byte payloads with random s_valid/m_ready -> CRC bytes match the bit-serial golden model; no byte lost or duplicated.
- arstn asserted during CRC_HI -> m_valid=0 immediately, state IDLE; the next frame {0xFF} yields A5,FF,0F,00.
- With CRC12_FRAME_TX_MAXLEN_EN, MAX_LEN=2, payload 00,00,00 (last on 3rd byte):
  - frame 1 = A5,00,00,CRC(00 00) per golden model, with err pulse;
  - frame 2 = A5,00,09,06.
